// File: rtl/step_pulse_gen_pkg.sv
// Shared types and default timing for the STEP/DIR pulse generator.
package step_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    DIR_SETUP = 2'd1,
    STEP_HIGH = 2'd2,
    STEP_LOW  = 2'd3
  } step_state_e;

  localparam int CLK_HZ = 50_000_000;

  // 2 us step high time and 5 us direction setup at CLK_HZ.
  localparam int DEF_PULSE_W_CYC   = CLK_HZ / 500_000;
  localparam int DEF_DIR_SETUP_CYC = CLK_HZ / 200_000;
  localparam int DEF_MIN_PERIOD    = 200;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/step_pulse_gen_if.sv
// Tracking-stage <-> step generator signal bundle.
// master: tracking stage (drives requests); slave: step generator.
interface step_pulse_gen_if #(
  parameter int PERIOD_W = 17,
  parameter int POS_W    = 32
);

  logic                       enable;
  logic                       dir_in;
  logic [PERIOD_W-1:0]        period_in;
  logic                       step_out;
  logic                       dir_out;
  logic                       busy;
  logic                       step_done;
  logic                       period_clamped;
  logic signed [POS_W-1:0]    position;

  modport master (
    output enable, dir_in, period_in,
    input  step_out, dir_out, busy, step_done, period_clamped, position
  );

  modport slave (
    input  enable, dir_in, period_in,
    output step_out, dir_out, busy, step_done, period_clamped, position
  );

endinterface

// File: rtl/step_pulse_gen_timer.sv
// Loadable up-counter with clear/enable and a terminal-count compare.
// One instance is time-shared by the setup, high and low phases.
module step_timer #(
  parameter int CNT_W = 17
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr_i,
  input  logic             en_i,
  input  logic             load_i,
  input  logic [CNT_W-1:0] load_val_i,
  input  logic [CNT_W-1:0] term_i,
  output logic             tc_o
);

  logic [CNT_W-1:0] cnt_q;

  // Counter register: clear wins over load, load wins over count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (clr_i) begin
      cnt_q <= '0;
    end else if (load_i) begin
      cnt_q <= load_val_i;
    end else if (en_i) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign tc_o = (cnt_q == term_i);

endmodule

// File: rtl/step_pulse_gen.sv
// STEP/DIR waveform generator for the stepper driver, with guaranteed
// pulse width, direction setup time and a signed position count.
//
// state     | meaning
// IDLE      | no motion; launch decision evaluated every cycle
// DIR_SETUP | dir_out just changed; holding off the next rising edge
// STEP_HIGH | step_out high for PULSE_W_CYC cycles, never truncated
// STEP_LOW  | rest of the period; launch decision at counter = period-1
module step_pulse_gen
  import step_pkg::*;
#(
  parameter int PERIOD_W      = 17,
  parameter int PULSE_W_CYC   = DEF_PULSE_W_CYC,
  parameter int DIR_SETUP_CYC = DEF_DIR_SETUP_CYC,
  // Must exceed PULSE_W_CYC + 1 so STEP_LOW always has room to run.
  parameter int MIN_PERIOD    = DEF_MIN_PERIOD,
  parameter int POS_W         = 32
) (
  input  logic              clk,
  input  logic              rst,
  step_pulse_gen_if.slave   bus
);

  localparam int CNT_W = max_int(PERIOD_W, $clog2(DIR_SETUP_CYC + 1));

  step_state_e             state_q;
  logic                    step_out_q;
  logic                    dir_out_q;
  logic                    busy_q;
  logic                    step_done_q;
  logic                    period_clamped_q;
  logic signed [POS_W-1:0] position_q;
  logic [CNT_W-1:0]        period_lat_q;

  logic [CNT_W-1:0]        period_ext;
  logic [CNT_W-1:0]        period_lat_d;
  logic [CNT_W-1:0]        term;
  logic                    go_ok;
  logic                    dir_chg;
  logic                    decide_pt;
  logic                    launch_setup;
  logic                    launch_high;
  logic                    clamp_hit;
  logic                    tmr_clr;
  logic                    tmr_en;
  logic                    tmr_tc;

  // Launch decision, period clamp and timer terminal selection.
  always_comb begin
    period_ext   = CNT_W'(bus.period_in);
    go_ok        = bus.enable && (bus.period_in != '0);
    dir_chg      = (bus.dir_in != dir_out_q);
    clamp_hit    = (period_ext != '0) && (period_ext < CNT_W'(MIN_PERIOD));
    period_lat_d = clamp_hit ? CNT_W'(MIN_PERIOD) : period_ext;
    decide_pt    = (state_q == IDLE) || ((state_q == STEP_LOW) && tmr_tc);
    launch_setup = decide_pt && go_ok && dir_chg;
    // Leaving DIR_SETUP needs a live request; a stop (period 0) during
    // setup is treated like enable dropping.
    launch_high  = (decide_pt && go_ok && !dir_chg) ||
                   ((state_q == DIR_SETUP) && tmr_tc && go_ok);
    tmr_clr      = launch_setup || launch_high;
    tmr_en       = (state_q != IDLE);
    case (state_q)
      DIR_SETUP: term = CNT_W'(DIR_SETUP_CYC - 1);
      STEP_HIGH: term = CNT_W'(PULSE_W_CYC - 1);
      STEP_LOW:  term = period_lat_q - CNT_W'(1);
      default:   term = '0;
    endcase
  end

  step_timer #(
    .CNT_W (CNT_W)
  ) u_timer (
    .clk        (clk),
    .rst        (rst),
    .clr_i      (tmr_clr),
    .en_i       (tmr_en),
    .load_i     (1'b0),
    .load_val_i ('0),
    .term_i     (term),
    .tc_o       (tmr_tc)
  );

  // Sequencer state and all registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q          <= IDLE;
      step_out_q       <= 1'b0;
      dir_out_q        <= 1'b0;
      busy_q           <= 1'b0;
      step_done_q      <= 1'b0;
      period_clamped_q <= 1'b0;
      position_q       <= '0;
      period_lat_q     <= '0;
    end else begin
      step_done_q      <= 1'b0;
      period_clamped_q <= 1'b0;
      if (launch_setup) begin
        state_q   <= DIR_SETUP;
        dir_out_q <= bus.dir_in;
        busy_q    <= 1'b1;
      end else if (launch_high) begin
        state_q          <= STEP_HIGH;
        step_out_q       <= 1'b1;
        busy_q           <= 1'b1;
        period_lat_q     <= period_lat_d;
        period_clamped_q <= clamp_hit;
      end else begin
        case (state_q)
          DIR_SETUP: begin
            if (!bus.enable || tmr_tc) begin
              state_q <= IDLE;
              busy_q  <= 1'b0;
            end
          end
          STEP_HIGH: begin
            if (tmr_tc) begin
              state_q     <= STEP_LOW;
              step_out_q  <= 1'b0;
              step_done_q <= 1'b1;
              position_q  <= dir_out_q ? position_q + POS_W'(1)
                                       : position_q - POS_W'(1);
            end
          end
          STEP_LOW: begin
            if (!bus.enable || tmr_tc) begin
              state_q <= IDLE;
              busy_q  <= 1'b0;
            end
          end
          default: begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign bus.step_out       = step_out_q;
  assign bus.dir_out        = dir_out_q;
  assign bus.busy           = busy_q;
  assign bus.step_done      = step_done_q;
  assign bus.period_clamped = period_clamped_q;
  assign bus.position       = position_q;

endmodule

// File: tb/tb_step_pulse_gen.sv
// Directed bench for step_pulse_gen with PULSE_W_CYC=4, DIR_SETUP_CYC=6,
// MIN_PERIOD=10. Flags are packed as {step_out, dir_out, busy, step_done,
// period_clamped}.
module tb_step_pulse_gen;

  localparam int PERIOD_W = 17;
  localparam int POS_W    = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;
  int   rises  = 0;
  logic step_prev = 1'b0;

  typedef struct {
    logic       en;
    logic       dir;
    int         per;
    int         n;
    logic [4:0] flags;
    int         pos;
  } vec_t;

  vec_t vecs[$];

  step_pulse_gen_if #(.PERIOD_W(PERIOD_W), .POS_W(POS_W)) bus ();

  step_pulse_gen #(
    .PERIOD_W      (PERIOD_W),
    .PULSE_W_CYC   (4),
    .DIR_SETUP_CYC (6),
    .MIN_PERIOD    (10),
    .POS_W         (POS_W)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Count step_out rising edges as seen at the falling clock edge.
  always @(negedge clk) begin
    if (bus.step_out && !step_prev) rises++;
    step_prev = bus.step_out;
  end

  function automatic int flags_now();
    return int'({bus.step_out, bus.dir_out, bus.busy, bus.step_done, bus.period_clamped});
  endfunction

  function automatic int pos_now();
    return int'($signed(bus.position));
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", nm, act, act, exp, exp);
    end
  endtask

  task automatic add(input logic en, input logic dir, input int per, input int n,
                     input logic [4:0] flags, input int pos);
    vec_t v;
    v.en = en; v.dir = dir; v.per = per; v.n = n; v.flags = flags; v.pos = pos;
    vecs.push_back(v);
  endtask

  initial begin
    bus.enable    = 1'b0;
    bus.dir_in    = 1'b0;
    bus.period_in = '0;

    // Steady negative stepping at period 20.
    add(1, 0, 20,  1, 5'b10100,  0);
    add(1, 0, 20,  3, 5'b10100,  0);
    add(1, 0, 20,  1, 5'b00110, -1);
    add(1, 0, 20,  1, 5'b00100, -1);
    add(1, 0, 20, 15, 5'b10100, -1);
    add(1, 0, 20,  4, 5'b00110, -2);
    // Direction flip requested mid STEP_LOW.
    add(1, 1, 20, 15, 5'b00100, -2);
    add(1, 1, 20,  1, 5'b01100, -2);
    add(1, 1, 20,  5, 5'b01100, -2);
    add(1, 1, 20,  1, 5'b11100, -2);
    add(1, 1, 20,  4, 5'b01110, -1);
    // Period change 20 -> 30 mid interval.
    add(1, 1, 30, 15, 5'b01100, -1);
    add(1, 1, 30,  1, 5'b11100, -1);
    add(1, 1, 30,  4, 5'b01110,  0);
    add(1, 1, 30, 25, 5'b01100,  0);
    add(1, 1, 30,  1, 5'b11100,  0);
    // Period 3 clamps to 10.
    add(1, 1,  3, 29, 5'b01100,  1);
    add(1, 1,  3,  1, 5'b11101,  1);
    add(1, 1,  3,  1, 5'b11100,  1);
    add(1, 1,  3,  3, 5'b01110,  2);
    add(1, 1,  3,  6, 5'b11101,  2);
    // Enable dropped on the 2nd STEP_HIGH cycle.
    add(1, 1,  3,  1, 5'b11100,  2);
    add(0, 1,  3,  3, 5'b01110,  3);
    add(0, 1,  3,  1, 5'b01000,  3);
    add(0, 1,  3, 20, 5'b01000,  3);
    // Dir change with period 0: stay idle, dir_out untouched.
    add(1, 0,  0,  3, 5'b01000,  3);
    // Dir change from idle, then enable dropped during setup.
    add(1, 0,  3,  1, 5'b00100,  3);
    add(0, 0,  3,  2, 5'b00000,  3);

    repeat (3) @(negedge clk);
    chk("reset_flags", flags_now(), 0);
    chk("reset_pos", pos_now(), 0);
    rst = 1'b0;

    foreach (vecs[i]) begin
      bus.enable    = vecs[i].en;
      bus.dir_in    = vecs[i].dir;
      bus.period_in = PERIOD_W'(vecs[i].per);
      repeat (vecs[i].n) @(posedge clk);
      @(negedge clk);
      chk($sformatf("vec%0d_flags", i), flags_now(), int'(vecs[i].flags));
      chk($sformatf("vec%0d_pos", i), pos_now(), vecs[i].pos);
    end

    chk("rise_count", rises, 7);

    // Asynchronous reset in the middle of a positive-direction pulse.
    bus.enable    = 1'b1;
    bus.dir_in    = 1'b1;
    bus.period_in = PERIOD_W'(20);
    repeat (7) @(posedge clk);
    #2;
    chk("pre_rst_step_dir", int'({bus.step_out, bus.dir_out}), 3);
    rst = 1'b1;
    #1;
    chk("async_rst_flags", flags_now(), 0);
    chk("async_rst_pos", pos_now(), 0);
    bus.dir_in = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_rise", flags_now(), 5'b10100);
    repeat (4) @(negedge clk);
    chk("post_rst_done", flags_now(), 5'b00110);
    chk("post_rst_pos", pos_now(), -1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
